// File: rtl/cpu_regfile_ctrl.sv
// cpu_regfile_ctrl: sequences single instructions against an external register
// file with registered reads. ALU ops run IDLE->READ->EXEC->WRITE (one per
// state, one op per 4 cycles). LDI writes the immediate directly. NOP and
// undefined opcodes complete in IDLE.
// Optional feature: define CPU_REGFILE_CTRL_FLAGS_EN to build the carry/zero
// flag registers. Without it, flag_c/flag_z are tied to 0.
module cpu_regfile_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [AW-1:0] rs,
  output logic [AW-1:0] rt,
  output logic [AW-1:0] rd,
  output logic          output_enable,
  output logic          enable_write,
  output logic [DW-1:0] data_in,
  input  logic [DW-1:0] reg_a,
  input  logic [DW-1:0] reg_b,
  output logic          done,
  output logic          illegal,
  output logic          flag_c,
  output logic          flag_z
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd7;

  state_t        r_state;
  logic [3:0]    r_op;
  logic [AW-1:0] r_rd_cap;
  logic [AW-1:0] r_rs;
  logic [AW-1:0] r_rt;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_data_in;
  logic          r_oe;
  logic          r_we;
  logic          r_done;
  logic          r_illegal;
  logic [DW-1:0] w_result;

  assign instr_ready   = (r_state == IDLE);
  assign rs            = r_rs;
  assign rt            = r_rt;
  assign rd            = r_rd;
  assign data_in       = r_data_in;
  assign output_enable = r_oe;
  assign enable_write  = r_we;
  assign done          = r_done;
  assign illegal       = r_illegal;

  // ALU on the operands returned by the register file during EXEC
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_ADD:  w_result = reg_a + reg_b;
      OP_SUB:  w_result = reg_a - reg_b;
      OP_AND:  w_result = reg_a & reg_b;
      OP_OR:   w_result = reg_a | reg_b;
      OP_XOR:  w_result = reg_a ^ reg_b;
      OP_MOV:  w_result = reg_a;
      default: w_result = '0;
    endcase
  end

  // Control FSM with registered strobes; strobes default low each cycle so
  // every one of them is a single-cycle pulse, while addresses/data hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_op      <= OP_NOP;
      r_rd_cap  <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_data_in <= '0;
      r_oe      <= 1'b0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_oe      <= 1'b0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        IDLE: begin
          if (instr_valid) begin
            r_op     <= instr[15:12];
            r_rd_cap <= AW'(instr[11:8]);
            case (instr[15:12])
              OP_NOP: begin
                r_done <= 1'b1;
              end
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: begin
                r_rs    <= AW'(instr[7:4]);
                r_rt    <= AW'(instr[3:0]);
                r_oe    <= 1'b1;
                r_state <= READ;
              end
              OP_LDI: begin
                r_rd      <= AW'(instr[11:8]);
                r_data_in <= DW'(instr[7:0]);
                r_we      <= 1'b1;
                r_done    <= 1'b1;
                r_state   <= WRITE;
              end
              default: begin
                r_done    <= 1'b1;
                r_illegal <= 1'b1;
              end
            endcase
          end
        end
        READ: begin
          r_state <= EXEC;
        end
        EXEC: begin
          r_rd      <= r_rd_cap;
          r_data_in <= w_result;
          r_we      <= 1'b1;
          r_done    <= 1'b1;
          r_state   <= WRITE;
        end
        WRITE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef CPU_REGFILE_CTRL_FLAGS_EN
  logic r_flag_c;
  logic r_flag_z;

  // Flags change together with the write-back of ADD/SUB/AND/OR/XOR only.
  // ADD carry: the wrapped sum is smaller than an addend. SUB borrow: a < b.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (r_state == EXEC && r_op inside {[OP_ADD:OP_XOR]}) begin
      if (r_op == OP_ADD) begin
        r_flag_c <= (w_result < reg_a);
      end else if (r_op == OP_SUB) begin
        r_flag_c <= (reg_a < reg_b);
      end else begin
        r_flag_c <= 1'b0;
      end
      r_flag_z <= (w_result == '0);
    end
  end

  assign flag_c = r_flag_c;
  assign flag_z = r_flag_z;
`else
  assign flag_c = 1'b0;
  assign flag_z = 1'b0;
`endif

endmodule
